wfg_drive_spi_mc: RTL and testbench
===================================

// Module: wfg_drive_spi_mc
// PURPOSE
//  Parametrised multi-chip-select SPI drive stage of the waveform generator core.
//  - Takes sample words from the wfg stream (valid/ready) and shifts each out as one SPI frame.
//  - Frame has programmable word width, SPI mode (CPOL/CPHA), bit order, SCLK divider and target chip select.
//  - Successor to the fixed 3-pin SPI drive; feeds the user IO pads together with per-pin output enables.
// PARAMETERS
//  DATA_W    32  maximum word width in bits, and the stream data width
//  NUM_CS     4  number of chip-select outputs
//  CLKDIV_W   8  width of the SCLK half-period divider field
// PORTS
//  clk               in   1                     core clock, the only clock
//  rst_n             in   1                     synchronous active-low reset
//  en_i              in   1                     block enable
//  cfg_cpol_i        in   1                     SCLK idle level
//  cfg_cpha_i        in   1                     0: sample on leading edge; 1: sample on trailing edge
//  cfg_lsbfirst_i    in   1                     1: LSB shifted first
//  cfg_width_i       in   $clog2(DATA_W)        word width minus one
//  cfg_clkdiv_i      in   CLKDIV_W              SCLK half-period minus one, in clk cycles
//  cfg_cs_sel_i      in   $clog2(NUM_CS)        index of the chip select to assert
//  wfg_axis_tdata_i  in   DATA_W                sample word; bits above the configured width are ignored
//  wfg_axis_tvalid_i in   1                     sample valid
//  wfg_axis_tready_o out  1                     sample accepted when tvalid and tready are both high
//  spi_sclk_o        out  1                     SPI clock
//  spi_cs_no         out  NUM_CS                active-low chip selects
//  spi_sdo_o         out  1                     serial data out
//  spi_oeb_o         out  NUM_CS+2              pad output-enable bar: {cs, sdo, sclk}
//  busy_o            out  1                     frame in progress
// BEHAVIOUR
//  Reset values (rst_n=0 at a clk edge): state IDLE, spi_sclk_o=0, spi_cs_no=all 1, spi_sdo_o=0,
//    spi_oeb_o=all 1, tready=0, busy_o=0, counters 0.
//  Reset mid-frame aborts the frame. No partial word is retained.
//  Timing unit: H = cfg_clkdiv_i+1 clk cycles.
//  FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
//  IDLE
//  - tready = en_i; all outputs registered.
//  - spi_sclk_o = cfg_cpol_i; spi_cs_no = all 1; spi_sdo_o = 0; busy_o = 0.
//  - On accept: config and word are latched into shadow registers; config changes later in the frame have no effect.
//  LEAD (entered the cycle after accept, lasts H cycles)
//  - spi_cs_no[cs_sel] = 0; busy_o = 1; SCLK stays idle.
//  - CPHA=0: first bit is driven on SDO on entry to LEAD.
//  SHIFT (2*(width+1) SCLK edges, one every H cycles)
//  - SCLK toggles at each edge.
//  - CPHA=0: next bit is driven on each trailing edge, except the last one.
//  - CPHA=1: next bit is driven on each leading edge.
//  - Bit order is MSB-first from bit [width], or LSB-first from bit 0 when lsbfirst is set.
//  TRAIL (H cycles)
//  - SCLK idle, CS still asserted, SDO holds the last bit.
//  - Then IDLE: CS deasserted and tready high in the same cycle.
//  Frame timing:
//  - Accept to CS deassert = 1 + (2*(width+1)+2)*H cycles.
//  - Minimum CS-high gap between back-to-back frames = 1 cycle.
//  spi_oeb_o:
//  - Bits for sclk, sdo and every cs = ~en_i.
//  - Cs bits at index >= NUM_CS do not exist.
//  - If cs_sel >= NUM_CS: frame is clocked normally but no CS asserts.
//  en_i deasserted mid-frame: the frame completes, then tready stays 0.
//  width=0 is legal and gives a 1-bit frame. clkdiv=0 gives SCLK = clk/2.
// TESTING
//  - Mode 0, clkdiv=0, width=7, MSB-first, cs_sel=0, data 0xA5
//    -> cs_n[0] low for 18 cycles; 8 rising edges sample 1,0,1,0,0,1,0,1; cs_n[3:1] stay 1.
//  - Mode 3 (cpol=1, cpha=1), clkdiv=3, width=15, LSB-first, cs_sel=2, data 0x8001
//    -> SCLK idles high, edges every 4 cycles, CS low 4*34=136 cycles; SDO samples 1, then 14x 0, then 1.
//  - tvalid held high, two words 0x12 and 0x34, width=7, clkdiv=1
//    -> two frames of 36 cycles each; CS high exactly 1 cycle between them; tready pulses once per word.
//  - cfg_width_i changed from 7 to 3 mid-frame -> current frame keeps 8 bits; next frame has 4 bits.
//  - en_i dropped in cycle 5 of a frame -> frame completes; tready stays 0; oeb goes all 1 immediately.
//  - rst_n=0 in the middle of SHIFT -> next cycle cs_n=all 1, sclk=0, sdo=0, busy=0; no stray SCLK edge afterwards.

Source files
------------

// File: rtl/wfg_drive_spi_mc.sv
// wfg_drive_spi_mc: multi chip-select SPI drive stage of the waveform generator.
// Shifts each accepted stream word out as one SPI frame with programmable
// word width, CPOL/CPHA, bit order, SCLK half-period divider and target CS.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   en_i                block enable (gates tready and pad output enables)
//   cfg_cpol_i          SCLK idle level
//   cfg_cpha_i          0: sample on leading edge, 1: sample on trailing edge
//   cfg_lsbfirst_i      1: LSB shifted first
//   cfg_width_i         word width minus one
//   cfg_clkdiv_i        SCLK half-period minus one, in clk cycles
//   cfg_cs_sel_i        index of the chip select to assert
//   wfg_axis_tdata_i    sample word
//   wfg_axis_tvalid_i   sample valid
//   wfg_axis_tready_o   sample ready
//   spi_sclk_o          SPI clock
//   spi_cs_no           active-low chip selects
//   spi_sdo_o           serial data out
//   spi_oeb_o           pad output-enable bar {cs, sdo, sclk}
//   busy_o              frame in progress

module wfg_drive_spi_mc #(
    parameter int DATA_W   = 32,
    parameter int NUM_CS   = 4,
    parameter int CLKDIV_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      cfg_cpol_i,
    input  logic                      cfg_cpha_i,
    input  logic                      cfg_lsbfirst_i,
    input  logic [$clog2(DATA_W)-1:0] cfg_width_i,
    input  logic [CLKDIV_W-1:0]       cfg_clkdiv_i,
    input  logic [$clog2(NUM_CS)-1:0] cfg_cs_sel_i,
    input  logic [DATA_W-1:0]         wfg_axis_tdata_i,
    input  logic                      wfg_axis_tvalid_i,
    output logic                      wfg_axis_tready_o,
    output logic                      spi_sclk_o,
    output logic [NUM_CS-1:0]         spi_cs_no,
    output logic                      spi_sdo_o,
    output logic [NUM_CS+1:0]         spi_oeb_o,
    output logic                      busy_o
);

    localparam int WW  = $clog2(DATA_W);
    localparam int CSW = $clog2(NUM_CS);
    // Edge counter holds up to 2*DATA_W
    localparam int EW  = WW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_e;

    state_e                state_q;

    // Shadow copies of the frame configuration and word
    logic [DATA_W-1:0]     data_q;
    logic [WW-1:0]         width_q;
    logic [CLKDIV_W-1:0]   div_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;

    logic [CLKDIV_W-1:0]   tmr_q;
    logic [EW-1:0]         edge_q;
    logic [WW-1:0]         nb_q;

    logic                  sclk_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic                  sdo_q;
    logic [NUM_CS+1:0]     oeb_q;
    logic                  tready_q;
    logic                  busy_q;

    logic                  accept;
    logic                  tmr_done;
    logic [EW-1:0]         edge_d;
    logic [EW-1:0]         n_edges;
    logic [WW-1:0]         nb_d;
    logic                  bit_d;

    // Bit k of the frame, counted from the first bit shifted out
    function automatic logic pick_bit(
        input logic [DATA_W-1:0] d,
        input logic [WW-1:0]     w,
        input logic              lsb,
        input logic [WW-1:0]     k
    );
        logic [WW-1:0] idx;
        idx = lsb ? k : (w - k);
        return d[idx];
    endfunction

    // Out-of-range selects leave every CS deasserted
    function automatic logic [NUM_CS-1:0] cs_dec(
        input logic [CSW-1:0] sel
    );
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CSW'(i)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    assign accept   = wfg_axis_tvalid_i & tready_q;
    assign tmr_done = (tmr_q == div_q);
    assign edge_d   = edge_q + EW'(1);
    assign n_edges  = {1'b0, width_q, 1'b0} + EW'(2);
    assign nb_d     = nb_q + WW'(1);
    assign bit_d    = pick_bit(data_q, width_q, lsb_q, nb_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            width_q  <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tmr_q    <= '0;
            edge_q   <= '0;
            nb_q     <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= '1;
            sdo_q    <= 1'b0;
            oeb_q    <= '1;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            oeb_q <= {(NUM_CS+2){~en_i}};
            unique case (state_q)
                S_IDLE: begin
                    sclk_q   <= cfg_cpol_i;
                    cs_n_q   <= '1;
                    sdo_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    tready_q <= en_i;
                    if (accept) begin
                        state_q  <= S_LEAD;
                        data_q   <= wfg_axis_tdata_i;
                        width_q  <= cfg_width_i;
                        div_q    <= cfg_clkdiv_i;
                        cpol_q   <= cfg_cpol_i;
                        cpha_q   <= cfg_cpha_i;
                        lsb_q    <= cfg_lsbfirst_i;
                        tmr_q    <= '0;
                        edge_q   <= '0;
                        tready_q <= 1'b0;
                        busy_q   <= 1'b1;
                        cs_n_q   <= cs_dec(cfg_cs_sel_i);
                        // CPHA=0 presents the first bit before any edge
                        if (!cfg_cpha_i) begin
                            sdo_q <= pick_bit(wfg_axis_tdata_i,
                                              cfg_width_i,
                                              cfg_lsbfirst_i,
                                              '0);
                            nb_q  <= WW'(1);
                        end else begin
                            nb_q  <= '0;
                        end
                    end
                end

                S_LEAD: begin
                    if (tmr_done) begin
                        tmr_q   <= '0;
                        state_q <= S_SHIFT;
                        sclk_q  <= ~cpol_q;
                        edge_q  <= EW'(1);
                        // First edge is leading: CPHA=1 drives here
                        if (cpha_q) begin
                            sdo_q <= bit_d;
                            nb_q  <= nb_d;
                        end
                    end else begin
                        tmr_q <= tmr_q + CLKDIV_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (tmr_done) begin
                        tmr_q <= '0;
                        if (edge_q == n_edges) begin
                            state_q <= S_TRAIL;
                        end else begin
                            sclk_q <= ~sclk_q;
                            edge_q <= edge_d;
                            // Odd edge numbers are leading edges
                            if (cpha_q == edge_d[0]) begin
                                if (edge_d != n_edges) begin
                                    sdo_q <= bit_d;
                                    nb_q  <= nb_d;
                                end
                            end
                        end
                    end else begin
                        tmr_q <= tmr_q + CLKDIV_W'(1);
                    end
                end

                S_TRAIL: begin
                    if (tmr_done) begin
                        tmr_q    <= '0;
                        state_q  <= S_IDLE;
                        cs_n_q   <= '1;
                        sclk_q   <= cfg_cpol_i;
                        sdo_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        tready_q <= en_i;
                    end else begin
                        tmr_q <= tmr_q + CLKDIV_W'(1);
                    end
                end
            endcase
        end
    end

    assign wfg_axis_tready_o = tready_q;
    assign spi_sclk_o        = sclk_q;
    assign spi_cs_no         = cs_n_q;
    assign spi_sdo_o         = sdo_q;
    assign spi_oeb_o         = oeb_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// tb_wfg_drive_spi_mc: bench for the multi-CS SPI drive stage.
// Frames are observed at the pins and compared with arithmetic expectations.

module tb_wfg_drive_spi_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        cfg_cpol_i = 1'b0;
    logic        cfg_cpha_i = 1'b0;
    logic        cfg_lsbfirst_i = 1'b0;
    logic [4:0]  cfg_width_i = '0;
    logic [7:0]  cfg_clkdiv_i = '0;
    logic [1:0]  cfg_cs_sel_i = '0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        sclk;
    logic [3:0]  cs_n;
    logic        sdo;
    logic [5:0]  oeb;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wfg_drive_spi_mc #(
        .DATA_W   (32),
        .NUM_CS   (4),
        .CLKDIV_W (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .en_i              (en_i),
        .cfg_cpol_i        (cfg_cpol_i),
        .cfg_cpha_i        (cfg_cpha_i),
        .cfg_lsbfirst_i    (cfg_lsbfirst_i),
        .cfg_width_i       (cfg_width_i),
        .cfg_clkdiv_i      (cfg_clkdiv_i),
        .cfg_cs_sel_i      (cfg_cs_sel_i),
        .wfg_axis_tdata_i  (tdata),
        .wfg_axis_tvalid_i (tvalid),
        .wfg_axis_tready_o (tready),
        .spi_sclk_o        (sclk),
        .spi_cs_no         (cs_n),
        .spi_sdo_o         (sdo),
        .spi_oeb_o         (oeb),
        .busy_o            (busy)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: drive config + word, watch pins until CS rises.
    task automatic run_frame(input bit cpol, input bit cpha,
                             input bit lsb, input int w,
                             input int div, input int sel,
                             input logic [31:0] data,
                             input int chg_at, input int chg_w,
                             input int drop_at);
        int h, n, low, edges, first, last, nbit, rise;
        bit gap_ok, oth_ok, busy_ok, acc;
        logic prev;
        logic [31:0] recv;
        logic [63:0] mask;
        h = div + 1;
        n = w + 1;
        mask = (64'd1 << n) - 64'd1;
        low = 0; edges = 0; first = 0; last = 0; nbit = 0; rise = 0;
        gap_ok = 1; oth_ok = 1; busy_ok = 1; acc = 0;
        recv = '0;
        cfg_cpol_i = cpol;
        cfg_cpha_i = cpha;
        cfg_lsbfirst_i = lsb;
        cfg_width_i = 5'(w);
        cfg_clkdiv_i = 8'(div);
        cfg_cs_sel_i = 2'(sel);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sclk", sclk, cpol);
        tdata = data;
        tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tready === 1'b1) begin
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept", acc, 1);
        if (!acc) begin
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tdata = $urandom;
        prev = cpol;
        for (int k = 1; k <= (2 * n + 2) * h + 20; k++) begin
            @(negedge clk);
            if (cs_n[sel] === 1'b0) begin
                low++;
                if (busy !== 1'b1) busy_ok = 0;
            end else if (low > 0) begin
                rise = k;
                break;
            end
            for (int j = 0; j < 4; j++) begin
                if (j != sel && cs_n[j] !== 1'b1) oth_ok = 0;
            end
            if (sclk !== prev) begin
                edges++;
                if (edges == 1) first = k;
                else if (k - last != h) gap_ok = 0;
                last = k;
                // CPHA=0 samples odd edges, CPHA=1 even edges
                if ((edges % 2 == 1) != cpha) begin
                    if (lsb) recv[nbit] = sdo;
                    else recv = {recv[30:0], sdo};
                    nbit++;
                end
                prev = sclk;
            end
            if (k == chg_at) cfg_width_i = 5'(chg_w);
            if (k == drop_at) en_i = 1'b0;
            if (drop_at > 0 && k == drop_at + 1)
                check("oeb_drop", oeb, 6'h3F);
        end
        check("cs_rise_seen", rise != 0, 1);
        check("cs_low_len", low, (2 * n + 2) * h);
        check("sclk_edges", edges, 2 * n);
        check("first_edge", first, h + 1);
        check("edge_gap", gap_ok, 1);
        check("bit_count", nbit, n);
        check("frame_bits", {32'd0, recv}, {32'd0, data} & mask);
        check("other_cs", oth_ok, 1);
        check("busy_in_frame", busy_ok, 1);
        check("end_busy", busy, 0);
        check("end_sclk", sclk, cpol);
        check("end_sdo", sdo, 0);
        check("end_tready", tready, en_i);
        check("end_oeb", oeb, {6{~en_i}});
    endtask

    initial begin
        int runs[2];
        int r, len, gap, nacc, trc, edges;
        bit will, cs_ok;
        logic prev_cs, prev;

        // Reset state
        rst_n = 1'b0;
        en_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_sdo", sdo, 0);
        check("rst_oeb", oeb, 6'h3F);
        check("rst_tready", tready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tready", tready, 1);
        check("idle_oeb", oeb, 6'h00);

        // Mode 0, 8-bit MSB-first
        run_frame(0, 0, 0, 7, 0, 0, 32'hA5, 0, 0, 0);
        // Mode 3, 16-bit LSB-first, CS 2
        run_frame(1, 1, 1, 15, 3, 2, 32'h8001, 0, 0, 0);
        // Width changed mid-frame, then a 4-bit frame
        run_frame(0, 1, 0, 7, 0, 1, 32'hC3, 5, 3, 0);
        run_frame(0, 1, 0, 3, 0, 1, 32'h9, 0, 0, 0);
        // One-bit frames
        run_frame(1, 0, 1, 0, 0, 2, 32'h1, 0, 0, 0);
        run_frame(0, 1, 0, 0, 2, 3, 32'hFFFF_FFFE, 0, 0, 0);
        // Full-width word
        run_frame(0, 0, 1, 31, 0, 3, 32'hDEAD_BEEF, 0, 0, 0);

        // Back-to-back frames with tvalid held
        cfg_cpol_i = 0; cfg_cpha_i = 0; cfg_lsbfirst_i = 0;
        cfg_width_i = 5'd7; cfg_clkdiv_i = 8'd1; cfg_cs_sel_i = 2'd1;
        repeat (2) @(negedge clk);
        tdata = 32'h12;
        tvalid = 1'b1;
        runs[0] = 0; runs[1] = 0;
        r = 0; len = 0; gap = 0; nacc = 0; trc = 0;
        prev_cs = 1'b1;
        for (int i = 0; i < 150; i++) begin
            will = (tready === 1'b1) && tvalid;
            if (tvalid && tready === 1'b1) trc++;
            if (cs_n[1] === 1'b0) len++;
            if (cs_n[1] === 1'b1 && prev_cs === 1'b0) begin
                runs[r] = len;
                r++;
                len = 0;
            end
            if (r == 1 && cs_n[1] === 1'b1) gap++;
            prev_cs = cs_n[1];
            if (r == 2) break;
            if (will) begin
                @(posedge clk);
                #1;
                nacc++;
                if (nacc == 1) tdata = 32'h34;
                else tvalid = 1'b0;
            end
            @(negedge clk);
        end
        tvalid = 1'b0;
        check("b2b_run0", runs[0], 36);
        check("b2b_run1", runs[1], 36);
        check("b2b_gap", gap, 1);
        check("b2b_accepts", nacc, 2);
        check("b2b_tready", trc, 2);

        // en_i dropped in cycle 5 of a frame
        run_frame(0, 0, 0, 7, 1, 3, 32'h5A, 0, 0, 5);
        repeat (3) @(negedge clk);
        check("en_off_tready", tready, 0);
        check("en_off_oeb", oeb, 6'h3F);
        en_i = 1'b1;

        // Reset in the middle of SHIFT
        cfg_cpol_i = 0; cfg_cpha_i = 0; cfg_lsbfirst_i = 0;
        cfg_width_i = 5'd7; cfg_clkdiv_i = 8'd1; cfg_cs_sel_i = 2'd0;
        repeat (2) @(negedge clk);
        tdata = 32'hFF;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cs_n", cs_n, 4'hF);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_sdo", sdo, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tready", tready, 0);
        rst_n = 1'b1;
        edges = 0;
        cs_ok = 1;
        prev = sclk;
        repeat (40) begin
            @(negedge clk);
            if (sclk !== prev) edges++;
            if (cs_n !== 4'hF) cs_ok = 0;
            prev = sclk;
        end
        check("post_rst_edges", edges, 0);
        check("post_rst_cs", cs_ok, 1);

        // Randomized frames
        for (int t = 0; t < 16; t++) begin
            run_frame(1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      $urandom, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
